// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: holds the decoded instruction for one cycle,
// resolves MEM/WB forwarding for the ALU operands and flags load-use hazards.
module id_ex_stage #(
   parameter int         XLEN       = 32,
   parameter logic [3:0] NOP_ALU_OP = 4'd0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [3:0]      id_alu_op,
   input  logic            id_a_sel,
   input  logic            id_b_sel,
   input  logic            id_rf_we,
   input  logic            id_mem_we,
   input  logic            id_mem_re,
   input  logic            id_branch,
   input  logic            mem_rf_we,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_wd,
   input  logic            wb_rf_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_wd,
   output logic [XLEN-1:0] op_A,
   output logic [XLEN-1:0] op_B,
   output logic [3:0]      alu_op,
   output logic [XLEN-1:0] ex_pc,
   output logic [4:0]      ex_rd,
   output logic [XLEN-1:0] ex_store_data,
   output logic            ex_valid,
   output logic            ex_rf_we,
   output logic            ex_mem_we,
   output logic            ex_mem_re,
   output logic            ex_branch,
   output logic            load_use
);

   typedef struct packed {
      logic            valid;
      logic            rf_we;
      logic            mem_we;
      logic            mem_re;
      logic            branch;
      logic            a_sel;
      logic            b_sel;
      logic [3:0]      alu_op;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
   } bank_t;

   bank_t bank_reg, bank_next, bubble, captured;

   always_comb begin
      bubble        = '0;
      bubble.alu_op = NOP_ALU_OP;

      captured          = '0;
      captured.valid    = 1'b1;
      captured.rf_we    = id_rf_we;
      captured.mem_we   = id_mem_we;
      captured.mem_re   = id_mem_re;
      captured.branch   = id_branch;
      captured.a_sel    = id_a_sel;
      captured.b_sel    = id_b_sel;
      captured.alu_op   = id_alu_op;
      captured.rd       = id_rd;
      captured.rs1      = id_rs1;
      captured.rs2      = id_rs2;
      captured.pc       = id_pc;
      captured.rs1_data = id_rs1_data;
      captured.rs2_data = id_rs2_data;
      captured.imm      = id_imm;

      // flush outranks stall; an invalid decode slot becomes a bubble
      if (flush)
         bank_next = bubble;
      else if (stall)
         bank_next = bank_reg;
      else if (!id_valid)
         bank_next = bubble;
      else
         bank_next = captured;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_reg        <= '0;
         bank_reg.alu_op <= NOP_ALU_OP;
      end else begin
         bank_reg <= bank_next;
      end
   end

   logic [1:0][4:0]      rs_idx;
   logic [1:0][XLEN-1:0] rs_val;
   logic [1:0][XLEN-1:0] fwd;

   assign rs_idx[0] = bank_reg.rs1;
   assign rs_idx[1] = bank_reg.rs2;
   assign rs_val[0] = bank_reg.rs1_data;
   assign rs_val[1] = bank_reg.rs2_data;

   // MEM is younger than WB so it wins; x0 is hard-wired and never forwarded
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         assign fwd[gi] =
            (mem_rf_we && (mem_rd != 5'd0) && (mem_rd == rs_idx[gi])) ? mem_wd :
            (wb_rf_we  && (wb_rd  != 5'd0) && (wb_rd  == rs_idx[gi])) ? wb_wd  :
            rs_val[gi];
      end
   endgenerate

   assign op_A          = bank_reg.a_sel ? bank_reg.pc  : fwd[0];
   assign op_B          = bank_reg.b_sel ? bank_reg.imm : fwd[1];
   assign ex_store_data = fwd[1];
   assign alu_op        = bank_reg.alu_op;
   assign ex_pc         = bank_reg.pc;
   assign ex_rd         = bank_reg.rd;
   assign ex_valid      = bank_reg.valid;
   assign ex_rf_we      = bank_reg.rf_we;
   assign ex_mem_we     = bank_reg.mem_we;
   assign ex_mem_re     = bank_reg.mem_re;
   assign ex_branch     = bank_reg.branch;

   // the hazard unit reacts by stalling IF/ID and flushing this stage
   assign load_use = bank_reg.valid && bank_reg.mem_re && (bank_reg.rd != 5'd0) && id_valid &&
                     ((bank_reg.rd == id_rs1) || (bank_reg.rd == id_rs2));

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected output sets are queued as
// stimulus is applied and compared once the stage presents them.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush, id_valid;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [3:0]  id_alu_op;
   logic        id_a_sel, id_b_sel, id_rf_we, id_mem_we, id_mem_re, id_branch;
   logic        mem_rf_we, wb_rf_we;
   logic [4:0]  mem_rd, wb_rd;
   logic [31:0] mem_wd, wb_wd;
   logic [31:0] op_A, op_B, ex_pc, ex_store_data;
   logic [3:0]  alu_op;
   logic [4:0]  ex_rd;
   logic        ex_valid, ex_rf_we, ex_mem_we, ex_mem_re, ex_branch, load_use;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [31:0] op_a;
      logic [31:0] op_b;
      logic [3:0]  alu;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] store;
      logic        valid;
      logic        rf_we;
      logic        mem_we;
      logic        mem_re;
      logic        branch;
      logic        lu;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_alu_op(id_alu_op), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
      .id_rf_we(id_rf_we), .id_mem_we(id_mem_we), .id_mem_re(id_mem_re), .id_branch(id_branch),
      .mem_rf_we(mem_rf_we), .mem_rd(mem_rd), .mem_wd(mem_wd),
      .wb_rf_we(wb_rf_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
      .op_A(op_A), .op_B(op_B), .alu_op(alu_op), .ex_pc(ex_pc), .ex_rd(ex_rd),
      .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_rf_we(ex_rf_we),
      .ex_mem_we(ex_mem_we), .ex_mem_re(ex_mem_re), .ex_branch(ex_branch), .load_use(load_use)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [31:0] pc,
                         input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2,
                         input logic [4:0] rd, input logic [31:0] imm, input logic [3:0] op,
                         input logic asel, input logic bsel, input logic rfwe,
                         input logic memwe, input logic memre, input logic br);
      id_valid = v;  id_pc = pc;  id_rs1 = rs1;  id_rs1_data = d1;
      id_rs2 = rs2;  id_rs2_data = d2;  id_rd = rd;  id_imm = imm;  id_alu_op = op;
      id_a_sel = asel;  id_b_sel = bsel;  id_rf_we = rfwe;
      id_mem_we = memwe;  id_mem_re = memre;  id_branch = br;
   endtask

   task automatic expect_out(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                             input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] st,
                             input logic v, input logic rfwe, input logic memwe,
                             input logic memre, input logic br, input logic lu);
      exp_t e;
      e = '{op_a: a, op_b: b, alu: op, pc: pc, rd: rd, store: st, valid: v,
            rf_we: rfwe, mem_we: memwe, mem_re: memre, branch: br, lu: lu};
      sb.push_back(e);
   endtask

   task automatic expect_bubble();
      expect_out(32'h0, 32'h0, 4'd0, 32'h0, 5'd0, 32'h0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic compare_out(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check_val({tag, " sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check_val({tag, " op_A"}, op_A, e.op_a);
      check_val({tag, " op_B"}, op_B, e.op_b);
      check_val({tag, " alu_op"}, {28'd0, alu_op}, {28'd0, e.alu});
      check_val({tag, " ex_pc"}, ex_pc, e.pc);
      check_val({tag, " ex_rd"}, {27'd0, ex_rd}, {27'd0, e.rd});
      check_val({tag, " store"}, ex_store_data, e.store);
      check_val({tag, " ctrl"}, {26'd0, ex_valid, ex_rf_we, ex_mem_we, ex_mem_re, ex_branch, load_use},
                {26'd0, e.valid, e.rf_we, e.mem_we, e.mem_re, e.branch, e.lu});
      $display("txn %s: op_A=%h op_B=%h store=%h valid=%b lu=%b", tag, op_A, op_B, ex_store_data,
               ex_valid, load_use);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;  stall = 1'b0;  flush = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      mem_rf_we = 0;  mem_rd = 0;  mem_wd = 0;
      wb_rf_we = 0;   wb_rd = 0;   wb_wd = 0;

      // reset holds the bubble
      step();  step();
      expect_bubble();
      compare_out("reset");
      rst = 1'b0;

      // ADD x3, x1, x2
      set_id(1, 32'h10, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'h0, 4'd0, 0, 0, 1, 0, 0, 0);
      step();
      expect_out(32'd5, 32'd7, 4'd0, 32'h10, 5'd3, 32'd7, 1, 1, 0, 0, 0, 0);
      compare_out("add");

      // asynchronous reset between edges clears the bank immediately
      #2 rst = 1'b1;
      #1;
      expect_bubble();
      compare_out("async_rst");
      #1 rst = 1'b0;
      step();
      expect_out(32'd5, 32'd7, 4'd0, 32'h10, 5'd3, 32'd7, 1, 1, 0, 0, 0, 0);
      compare_out("add_after_rst");

      // forwarding priority: MEM over WB over register data
      set_id(1, 32'h20, 5'd3, 32'h11, 5'd4, 32'h22, 5'd6, 32'h0, 4'd2, 0, 0, 1, 0, 0, 0);
      mem_rf_we = 1;  mem_rd = 5'd3;  mem_wd = 32'hAA;
      wb_rf_we  = 1;  wb_rd  = 5'd3;  wb_wd  = 32'hBB;
      step();
      expect_out(32'hAA, 32'h22, 4'd2, 32'h20, 5'd6, 32'h22, 1, 1, 0, 0, 0, 0);
      compare_out("fwd_mem");
      mem_rf_we = 0;
      #1;
      expect_out(32'hBB, 32'h22, 4'd2, 32'h20, 5'd6, 32'h22, 1, 1, 0, 0, 0, 0);
      compare_out("fwd_wb");
      mem_rf_we = 1;  mem_rd = 5'd4;  mem_wd = 32'hCC;
      #1;
      expect_out(32'hBB, 32'hCC, 4'd2, 32'h20, 5'd6, 32'hCC, 1, 1, 0, 0, 0, 0);
      compare_out("fwd_rs2_mem");
      mem_rf_we = 0;  wb_rf_we = 0;
      #1;
      expect_out(32'h11, 32'h22, 4'd2, 32'h20, 5'd6, 32'h22, 1, 1, 0, 0, 0, 0);
      compare_out("fwd_none");

      // x0 is never forwarded
      set_id(1, 32'h30, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 32'h0, 4'd0, 0, 0, 1, 0, 0, 0);
      mem_rf_we = 1;  mem_rd = 5'd0;  mem_wd = 32'hFFFF_FFFF;
      wb_rf_we  = 1;  wb_rd  = 5'd0;  wb_wd  = 32'h5;
      step();
      expect_out(32'h0, 32'h0, 4'd0, 32'h30, 5'd7, 32'h0, 1, 1, 0, 0, 0, 0);
      compare_out("x0_guard");
      mem_rf_we = 0;  wb_rf_we = 0;

      // LW x5, 8(x1) followed by a consumer of x5
      set_id(1, 32'h40, 5'd1, 32'h1000, 5'd0, 32'h0, 5'd5, 32'd8, 4'd0, 0, 1, 1, 0, 1, 0);
      step();
      set_id(1, 32'h44, 5'd6, 32'd9, 5'd5, 32'h77, 5'd8, 32'h0, 4'd0, 0, 0, 1, 0, 0, 0);
      #1;
      expect_out(32'h1000, 32'd8, 4'd0, 32'h40, 5'd5, 32'h0, 1, 1, 0, 1, 0, 1);
      compare_out("load_use");
      id_valid = 0;
      #1;
      expect_out(32'h1000, 32'd8, 4'd0, 32'h40, 5'd5, 32'h0, 1, 1, 0, 1, 0, 0);
      compare_out("lu_id_invalid");
      id_valid = 1;
      flush = 1;
      step();
      flush = 0;
      expect_bubble();
      compare_out("lu_flush");

      // stall holds; stall+flush loads a bubble
      set_id(1, 32'h50, 5'd2, 32'h123, 5'd3, 32'h456, 5'd9, 32'h0, 4'd5, 0, 0, 0, 0, 0, 1);
      step();
      expect_out(32'h123, 32'h456, 4'd5, 32'h50, 5'd9, 32'h456, 1, 0, 0, 0, 1, 0);
      compare_out("branch");
      stall = 1;
      set_id(1, 32'h60, 5'd7, 32'hDEAD, 5'd8, 32'hBEEF, 5'd11, 32'h4, 4'd3, 1, 1, 1, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         expect_out(32'h123, 32'h456, 4'd5, 32'h50, 5'd9, 32'h456, 1, 0, 0, 0, 1, 0);
         compare_out($sformatf("stall%0d", i));
      end
      flush = 1;
      step();
      expect_bubble();
      compare_out("stall_flush");
      stall = 0;  flush = 0;

      // PC / immediate operands; store data still forwarded rs2
      set_id(1, 32'h100, 5'd1, 32'h5, 5'd2, 32'h66, 5'd10, 32'hFFFF_FFFC, 4'd0, 1, 1, 1, 1, 0, 0);
      mem_rf_we = 1;  mem_rd = 5'd2;  mem_wd = 32'h99;
      step();
      expect_out(32'h100, 32'hFFFF_FFFC, 4'd0, 32'h100, 5'd10, 32'h99, 1, 1, 1, 0, 0, 0);
      compare_out("imm_pc_sel");
      mem_rf_we = 0;

      // invalid decode slot captures a bubble
      set_id(0, 32'h200, 5'd1, 32'h1, 5'd2, 32'h2, 5'd12, 32'h0, 4'd7, 0, 0, 1, 1, 1, 1);
      step();
      expect_bubble();
      compare_out("id_invalid");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
